// File: rtl/pdm_decimator.sv
// PDM-to-PCM decimator: generated PDM bit clock, 2-flop input sync,
// 3rd-order CIC (R=64, M=1, 20-bit wrap) and 16-bit saturated output.
module pdm_decimator #(
    parameter int CLK_DIV = 36,
    parameter int DECIM   = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic        pdm_data,
    output logic        pdm_clk,
    output logic [15:0] sample,
    output logic        sample_valid
);

    localparam int DIV_W = $clog2(CLK_DIV);
    localparam int DEC_W = $clog2(DECIM);
    localparam int ACC_W = 20;

    function automatic logic signed [15:0] scale_sat(input logic signed [ACC_W-1:0] c);
        logic signed [16:0] s;
        s = c[ACC_W-1:3];
        if (s > 17'sd32767)
            return 16'sh7FFF;
        else if (s < -17'sd32768)
            return 16'sh8000;
        else
            return s[15:0];
    endfunction

    logic                     r_meta;
    logic                     r_sync;
    logic                     r_run;
    logic [DIV_W-1:0]         r_div_cnt;
    logic                     r_pdm_clk;
    logic [DEC_W-1:0]         r_dec_cnt;
    logic [1:0]               r_warm;
    logic signed [ACC_W-1:0]  r_int1;
    logic signed [ACC_W-1:0]  r_int2;
    logic signed [ACC_W-1:0]  r_int3;
    logic signed [ACC_W-1:0]  r_dly1;
    logic signed [ACC_W-1:0]  r_dly2;
    logic signed [ACC_W-1:0]  r_dly3;
    logic signed [ACC_W-1:0]  r_comb_p1;
    logic                     r_vld_p1;
    logic signed [15:0]       r_sample_p2;
    logic                     r_vld_p2;

    logic                     w_act;
    logic                     w_last;
    logic                     w_strobe;
    logic                     w_event;
    logic [DIV_W-1:0]         w_cnt_nxt;
    logic signed [ACC_W-1:0]  w_x;
    logic signed [ACC_W-1:0]  w_int1_nxt;
    logic signed [ACC_W-1:0]  w_int2_nxt;
    logic signed [ACC_W-1:0]  w_int3_nxt;
    logic signed [ACC_W-1:0]  w_c1;
    logic signed [ACC_W-1:0]  w_c2;
    logic signed [ACC_W-1:0]  w_c3;

    // r_run lags en by one edge so counting starts from a full 0 cycle after
    // en rises or reset releases; en low still clears everything immediately.
    assign w_act     = en & r_run;
    assign w_last    = (r_div_cnt == DIV_W'(CLK_DIV - 1));
    assign w_strobe  = w_act & w_last;
    assign w_event   = w_strobe & (r_dec_cnt == DEC_W'(DECIM - 1));
    assign w_cnt_nxt = (w_act && !w_last) ? r_div_cnt + 1'b1 : '0;

    assign w_x        = r_sync ? 20'sd1 : -20'sd1;
    assign w_int1_nxt = r_int1 + w_x;
    assign w_int2_nxt = r_int2 + r_int1;
    assign w_int3_nxt = r_int3 + r_int2;

    assign w_c1 = w_int3_nxt - r_dly1;
    assign w_c2 = w_c1 - r_dly2;
    assign w_c3 = w_c2 - r_dly3;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_meta      <= 1'b0;
            r_sync      <= 1'b0;
            r_run       <= 1'b0;
            r_div_cnt   <= '0;
            r_pdm_clk   <= 1'b0;
            r_dec_cnt   <= '0;
            r_warm      <= '0;
            r_int1      <= '0;
            r_int2      <= '0;
            r_int3      <= '0;
            r_dly1      <= '0;
            r_dly2      <= '0;
            r_dly3      <= '0;
            r_comb_p1   <= '0;
            r_vld_p1    <= 1'b0;
            r_sample_p2 <= '0;
            r_vld_p2    <= 1'b0;
        end else begin
            r_meta    <= pdm_data;
            r_sync    <= r_meta;
            r_run     <= en;
            r_div_cnt <= w_cnt_nxt;
            r_pdm_clk <= en && (w_cnt_nxt < DIV_W'(CLK_DIV / 2));
            if (!en) begin
                r_dec_cnt <= '0;
                r_warm    <= '0;
                r_int1    <= '0;
                r_int2    <= '0;
                r_int3    <= '0;
                r_dly1    <= '0;
                r_dly2    <= '0;
                r_dly3    <= '0;
                r_vld_p1  <= 1'b0;
                r_vld_p2  <= 1'b0;
            end else begin
                // stage p0 -> p1: integrate on bit strobe, comb on decimation event
                if (w_strobe) begin
                    r_int1    <= w_int1_nxt;
                    r_int2    <= w_int2_nxt;
                    r_int3    <= w_int3_nxt;
                    r_dec_cnt <= (r_dec_cnt == DEC_W'(DECIM - 1)) ? '0 : r_dec_cnt + 1'b1;
                end
                r_vld_p1 <= 1'b0;
                if (w_event) begin
                    r_dly1    <= w_int3_nxt;
                    r_dly2    <= w_c1;
                    r_dly3    <= w_c2;
                    r_comb_p1 <= w_c3;
                    if (r_warm == 2'd3)
                        r_vld_p1 <= 1'b1;
                    else
                        r_warm <= r_warm + 1'b1;
                end
                // stage p1 -> p2: scale and saturate into the held output
                r_vld_p2 <= r_vld_p1;
                if (r_vld_p1)
                    r_sample_p2 <= scale_sat(r_comb_p1);
            end
        end
    end

    assign pdm_clk      = r_pdm_clk;
    assign sample       = r_sample_p2;
    assign sample_valid = r_vld_p2;

endmodule

// File: tb/tb_pdm_decimator.sv
// Bench for pdm_decimator: FIR-form CIC reference checked every cycle,
// plus directed latency, spacing, enable-drop and reset scenarios.
module tb_pdm_decimator;

    localparam int CLK_DIV = 8;
    localparam int HALF    = CLK_DIV / 2;
    localparam int FRAME   = CLK_DIV * 64;
    localparam int NTAP    = 190;
    localparam int LAT0    = 4 * FRAME + 2;

    logic        clk      = 1'b0;
    logic        rst_n    = 1'b0;
    logic        en       = 1'b0;
    logic        pdm_data = 1'b0;
    logic        pdm_clk;
    logic [15:0] sample;
    logic        sample_valid;

    always #5 clk = ~clk;

    pdm_decimator #(.CLK_DIV(CLK_DIV), .DECIM(64)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .en           (en),
        .pdm_data     (pdm_data),
        .pdm_clk      (pdm_clk),
        .sample       (sample),
        .sample_valid (sample_valid)
    );

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;
    int mode   = 0;
    int h[NTAP];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            if (n_fail <= 40)
                $display("FAIL %s at cycle %0d: got %0d, expected %0d", nm, cyc, act, exp);
        end
    endtask

    // Output of the CIC for the bit at index i, as a direct 190-tap convolution
    // with the two-bit integrator latency; bits before the start are zero.
    int bits[$];
    function automatic int fir_at(input int i);
        int y;
        int k;
        y = 0;
        for (int j = 0; j < NTAP; j++) begin
            k = i - 2 - j;
            if (k >= 0) y += h[j] * bits[k];
        end
        return y;
    endfunction

    function automatic int to_sample(input int y);
        int s;
        s = y >>> 3;
        if (s > 32767) s = 32767;
        if (s < -32768) s = -32768;
        return s;
    endfunction

    int m_phase  = 0;
    bit m_run    = 0;
    int m_nev    = 0;
    bit p1_v     = 0;
    int p1_val   = 0;
    bit e_valid  = 0;
    bit e_pclk   = 0;
    int e_sample = 0;

    initial begin
        bit act;
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                m_phase = 0; m_run = 0; m_nev = 0; p1_v = 0;
                e_valid = 0; e_pclk = 0; e_sample = 0;
                bits.delete();
            end else begin
                act = en && m_run;
                if (!en) begin
                    m_phase = 0; m_nev = 0; p1_v = 0; e_valid = 0;
                    bits.delete();
                end else begin
                    e_valid = p1_v;
                    if (p1_v) e_sample = p1_val;
                    p1_v = 0;
                    if (act && m_phase == CLK_DIV - 1) begin
                        bits.push_back(pdm_data ? 1 : -1);
                        if (bits.size() % 64 == 0) begin
                            m_nev++;
                            if (m_nev > 3) begin
                                p1_v   = 1;
                                p1_val = to_sample(fir_at(bits.size() - 1));
                            end
                        end
                    end
                    m_phase = act ? (m_phase + 1) % CLK_DIV : 0;
                end
                m_run  = en;
                e_pclk = en && (m_phase < HALF);
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            check("pdm_clk", int'(pdm_clk), int'(e_pclk));
            check("sample_valid", int'(sample_valid), int'(e_valid));
            check("sample", int'($signed(sample)), e_sample);
        end
    end

    initial begin
        forever begin
            @(posedge pdm_clk);
            #3;
            case (mode)
                0: pdm_data = 1'b0;
                1: pdm_data = 1'b1;
                2: pdm_data = ~pdm_data;
                default: pdm_data = ($urandom_range(0, 3) != 0);
            endcase
        end
    end

    task automatic wait_valid(input string nm, input int budget);
        int waited;
        waited = 0;
        @(negedge clk);
        while (!sample_valid && waited < budget) begin
            @(negedge clk);
            waited++;
        end
        if (!sample_valid) check({nm, "_timeout"}, 0, 1);
    endtask

    initial begin
        #1ms;
        $display("FAIL global_timeout at cycle %0d", cyc);
        $fatal(1, "simulation did not finish");
    end

    initial begin
        int h2[127];
        int hs, cp, prev, sum, nv, held;

        for (int i = 0; i < 127; i++) h2[i] = 0;
        for (int i = 0; i < NTAP; i++) h[i] = 0;
        for (int i = 0; i < 64; i++)
            for (int j = 0; j < 64; j++) h2[i + j] += 1;
        for (int i = 0; i < 127; i++)
            for (int j = 0; j < 64; j++) h[i + j] += h2[i];
        hs = 0;
        for (int i = 0; i < NTAP; i++) hs += h[i];
        check("model_gain", hs, 262144);
        check("model_h0", h[0], 1);
        check("model_h2", h[2], 6);
        check("model_h63", h[63], 2080);
        check("model_h189", h[189], 1);
        check("model_sat_pos", to_sample(262144), 32767);
        check("model_sat_neg", to_sample(-262144), -32768);
        check("model_shift_neg", to_sample(-9), -2);

        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("reset_sample", int'($signed(sample)), 0);
        check("reset_pclk", int'(pdm_clk), 0);

        // constant ones: three suppressed events, then full scale
        mode = 1;
        @(posedge clk); #1;
        cp = cyc;
        en = 1'b1;
        wait_valid("const1_first", LAT0 + 50);
        check("first_latency", cyc - cp, LAT0);
        check("const1_first_val", int'($signed(sample)), 32767);
        for (int n = 0; n < 4; n++) begin
            prev = cyc;
            wait_valid("const1", FRAME + 50);
            check("spacing", cyc - prev, FRAME);
        end
        check("const1_val", int'($signed(sample)), 32767);

        mode = 0;
        for (int n = 0; n < 6; n++) wait_valid("const0", FRAME + 50);
        check("const0_val", int'($signed(sample)), -32768);

        mode = 2;
        for (int n = 0; n < 6; n++) wait_valid("toggle", FRAME + 50);
        check("toggle_val", int'($signed(sample)), 0);

        mode = 3;
        sum = 0;
        for (int n = 0; n < 40; n++) begin
            wait_valid("random", FRAME + 50);
            sum += int'($signed(sample));
        end
        check("random_mean_in_range", int'((sum / 40) >= 12288 && (sum / 40) <= 20480), 1);

        // drop en on the edge where a result sits between the two output stages
        mode = 1;
        wait_valid("pre_drop", FRAME + 50);
        held = int'($signed(sample));
        repeat (FRAME - 1) @(posedge clk);
        #1 en = 1'b0;
        nv = 0;
        repeat (500) begin
            @(negedge clk);
            if (sample_valid) nv++;
        end
        check("valid_while_en_low", nv, 0);
        check("pclk_while_en_low", int'(pdm_clk), 0);
        check("sample_held", int'($signed(sample)), held);
        @(posedge clk); #1;
        cp = cyc;
        en = 1'b1;
        wait_valid("after_en", LAT0 + 50);
        check("en_restart_latency", cyc - cp, LAT0);
        check("en_restart_val", int'($signed(sample)), 32767);

        // reset pulse shortly after a bit-clock rising edge
        repeat (700) @(posedge clk);
        @(posedge pdm_clk);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_pclk", int'(pdm_clk), 0);
        check("async_rst_sample", int'($signed(sample)), 0);
        check("async_rst_valid", int'(sample_valid), 0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        cp = cyc;
        wait_valid("after_reset", LAT0 + 50);
        check("reset_gap_min", int'((cyc - cp) >= 4 * FRAME), 1);
        check("reset_release_latency", cyc - cp, LAT0);
        check("after_reset_val", int'($signed(sample)), 32767);

        repeat (4) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/pdm_decimator.md
PDM_DECIMATOR -- requirements
Module: pdm_decimator

Interface
REQ-001 Parameter CLK_DIV, default 36: clk cycles per PDM bit; even, 4..254.
REQ-002 Parameter DECIM, default 64: PDM bits per output sample; fixed at 64 (CIC gain 2^18 is baked into the scaling).
REQ-003 clk  in  1  system clock, 100 MHz; the block uses one clock.
REQ-004 rst_n  in  1  reset, asynchronous, active-low.
REQ-005 en  in  1  run enable, level.
REQ-006 pdm_data  in  1  PDM bitstream from a mic or sigma-delta modulator; asynchronous to clk.
REQ-007 pdm_clk  out  1  generated PDM bit clock, registered.
REQ-008 sample  out  16  signed PCM sample, held between updates.
REQ-009 sample_valid  out  1  one-cycle pulse when sample updates.

Function
REQ-010 Bit counter div_cnt SHALL count 0..CLK_DIV-1 and wrap while en=1, and SHALL be held at 0 while en=0.
REQ-011 pdm_clk SHALL be 1 for div_cnt in [0, CLK_DIV/2-1] and 0 otherwise, giving a 50% duty cycle; pdm_clk SHALL be 0 while en=0.
REQ-012 pdm_data SHALL pass through a two-flop synchronizer; a bit SHALL be captured from the synchronizer output on the cycle where div_cnt==CLK_DIV-1 (bit strobe).
REQ-013 Captured bit mapping: 1 -> +1, 0 -> -1.
REQ-014 Three cascaded integrators, 20-bit signed with wrap-around arithmetic, SHALL update once per bit strobe; wrap is legal and SHALL NOT be saturated.
REQ-015 Decimation counter SHALL count bit strobes 0..63; on strobe 63 the last integrator value SHALL enter three cascaded combs (differential delay 1, 20-bit wrap), which update only at decimation events.
REQ-016 Comb output c SHALL lie in [-262144, +262144]; sample SHALL be sat16(c >>> 3), with +32768 saturating to 32767.
REQ-017 sample and sample_valid SHALL register exactly 2 clk cycles after the decimation-event strobe cycle.
REQ-018 Output rate SHALL be one sample_valid per CLK_DIV*64 clk cycles; default spacing is 2304 cycles.
REQ-019 Warm-up: the first 3 decimation events after reset or after en rises SHALL update combs but SHALL NOT assert sample_valid or change sample.
REQ-020 Deasserting en SHALL, on the next cycle, clear div_cnt, the decimation counter, the integrators, the comb delays and the warm-up counter, and SHALL hold sample at its last value.
REQ-021 Deasserting en SHALL drop any decimation result still in the output pipeline, with no sample_valid.
REQ-022 en rising SHALL start div_cnt at 0 on the following cycle.
REQ-023 A bit strobe coinciding with en falling SHALL be discarded.

Reset
REQ-024 rst_n=0 SHALL asynchronously force: pdm_clk=0, sample=0, sample_valid=0, all counters, integrators, combs and synchronizer flops=0, warm-up counter=0.
REQ-025 Release of rst_n SHALL be taken synchronously, with the first div_cnt increment on the second clk edge after deassertion.
REQ-026 Reset asserted mid-frame SHALL abandon the partial frame with no sample_valid.

Verification
REQ-027 en=1, pdm_data=1 constant -> 3 suppressed events, then sample_valid every 2304 cycles; sample=32767 from the 4th event on.
REQ-028 pdm_data=0 constant -> sample=-32768 after warm-up; no wrap artefacts over 10000 outputs.
REQ-029 pdm_data toggling 1,0,1,0 per bit strobe -> sample=0 once the pipeline fills (by the 5th output).
REQ-030 Random bitstream with density p=0.75 -> sample mean within +/-64 of 16384 over 1000 outputs; compare against a bit-true CIC reference model.
REQ-031 en dropped mid-frame for 500 cycles, then raised -> no sample_valid while low; pdm_clk low; 3 suppressed events, then a correct value.
REQ-032 rst_n pulsed low for 3 cycles mid-frame -> outputs zero immediately; the next sample_valid arrives no earlier than 4*2304 cycles after release.
